// File: rtl/mips_pkg.sv
// Shared encodings for the multi-cycle MIPS control path: FSM states, opcodes,
// ALU operation classes, mux select codes and the packed control word.
package mips_pkg;

    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEMADR  = 4'd2,
        S_MEMRD   = 4'd3,
        S_MEMWB   = 4'd4,
        S_MEMWR   = 4'd5,
        S_EXECUTE = 4'd6,
        S_ALUWB   = 4'd7,
        S_BRANCH  = 4'd8,
        S_ADDIEX  = 4'd9,
        S_ORIEX   = 4'd10,
        S_IMMWB   = 4'd11,
        S_JUMP    = 4'd12
    } state_t;

    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_J     = 6'b000010;

    // Must stay aligned with the ALU decoder's aluop interpretation.
    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;
    localparam logic [1:0] ALUOP_OR    = 2'b11;

    localparam logic [1:0] SRCB_REG    = 2'b00;
    localparam logic [1:0] SRCB_FOUR   = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_BRANCH = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    typedef struct packed {
        logic       pcwrite;
        logic       branch;
        logic       iord;
        logic       memwrite;
        logic       irwrite;
        logic       regdst;
        logic       memtoreg;
        logic       regwrite;
        logic       alusrca;
        logic [1:0] alusrcb;
        logic       immzext;
        logic [1:0] pcsrc;
        logic [1:0] aluop;
    } ctrl_t;

    function automatic logic op_legal(input logic [5:0] op);
        return (op == OP_LW) || (op == OP_SW) || (op == OP_RTYPE) ||
               (op == OP_BEQ) || (op == OP_ADDI) || (op == OP_ORI) ||
               (op == OP_J);
    endfunction

endpackage

// File: rtl/mc_outdec.sv
// Combinational state -> control word table for the multi-cycle controller.
// Unused encodings decode to an all-zero control word.
module mc_outdec
    import mips_pkg::*;
(
    input  state_t st,
    output ctrl_t  ctrl
);

    always_comb begin
        ctrl = '0;
        case (st)
            S_FETCH: begin
                ctrl.irwrite = 1'b1;
                ctrl.alusrcb = SRCB_FOUR;
                ctrl.aluop   = ALUOP_ADD;
                ctrl.pcsrc   = PCSRC_ALU;
                ctrl.pcwrite = 1'b1;
            end
            S_DECODE: begin
                ctrl.alusrcb = SRCB_BRANCH;
                ctrl.aluop   = ALUOP_ADD;
            end
            S_MEMADR, S_ADDIEX: begin
                ctrl.alusrca = 1'b1;
                ctrl.alusrcb = SRCB_IMM;
                ctrl.aluop   = ALUOP_ADD;
            end
            S_MEMRD: ctrl.iord = 1'b1;
            S_MEMWB: begin
                ctrl.regwrite = 1'b1;
                ctrl.memtoreg = 1'b1;
            end
            S_MEMWR: begin
                ctrl.iord     = 1'b1;
                ctrl.memwrite = 1'b1;
            end
            S_EXECUTE: begin
                ctrl.alusrca = 1'b1;
                ctrl.alusrcb = SRCB_REG;
                ctrl.aluop   = ALUOP_FUNCT;
            end
            S_ALUWB: begin
                ctrl.regwrite = 1'b1;
                ctrl.regdst   = 1'b1;
            end
            S_BRANCH: begin
                ctrl.alusrca = 1'b1;
                ctrl.alusrcb = SRCB_REG;
                ctrl.aluop   = ALUOP_SUB;
                ctrl.pcsrc   = PCSRC_ALUOUT;
                ctrl.branch  = 1'b1;
            end
            S_ORIEX: begin
                ctrl.alusrca = 1'b1;
                ctrl.alusrcb = SRCB_IMM;
                ctrl.immzext = 1'b1;
                ctrl.aluop   = ALUOP_OR;
            end
            S_IMMWB: ctrl.regwrite = 1'b1;
            S_JUMP: begin
                ctrl.pcsrc   = PCSRC_JUMP;
                ctrl.pcwrite = 1'b1;
            end
            default: ctrl = '0;
        endcase
    end

endmodule

// File: rtl/mc_controller.sv
// Multi-cycle MIPS main control FSM (Moore); pcen and illegal are the only
// combinational-from-input outputs. Reset gates every write enable in its cycle.
module mc_controller
    import mips_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] op,
    input  logic       zero,
    output logic       pcen,
    output logic       iord,
    output logic       memwrite,
    output logic       irwrite,
    output logic       regdst,
    output logic       memtoreg,
    output logic       regwrite,
    output logic       alusrca,
    output logic [1:0] alusrcb,
    output logic       immzext,
    output logic [1:0] pcsrc,
    output logic [1:0] aluop,
    output logic       illegal,
    output logic [3:0] state
);

    state_t state_q;
    state_t state_d;
    state_t dec_state;
    ctrl_t  ctrl;

    always_ff @(posedge clk) begin
        if (reset) state_q <= S_FETCH;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = S_FETCH;
        case (state_q)
            S_FETCH: state_d = S_DECODE;
            S_DECODE: begin
                case (op)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_RTYPE:     state_d = S_EXECUTE;
                    OP_BEQ:       state_d = S_BRANCH;
                    OP_ADDI:      state_d = S_ADDIEX;
                    OP_ORI:       state_d = S_ORIEX;
                    OP_J:         state_d = S_JUMP;
                    default:      state_d = S_FETCH;
                endcase
            end
            S_MEMADR:  state_d = (op == OP_SW) ? S_MEMWR : S_MEMRD;
            S_MEMRD:   state_d = S_MEMWB;
            S_EXECUTE: state_d = S_ALUWB;
            S_ADDIEX:  state_d = S_IMMWB;
            S_ORIEX:   state_d = S_IMMWB;
            default:   state_d = S_FETCH;
        endcase
    end

    // During reset the datapath selects already show FETCH so the first fetch is clean.
    assign dec_state = reset ? S_FETCH : state_q;

    mc_outdec u_outdec (
        .st   (dec_state),
        .ctrl (ctrl)
    );

    assign pcen     = ~reset & (ctrl.pcwrite | (ctrl.branch & zero));
    assign irwrite  = ~reset & ctrl.irwrite;
    assign memwrite = ~reset & ctrl.memwrite;
    assign regwrite = ~reset & ctrl.regwrite;
    assign illegal  = ~reset & (state_q == S_DECODE) & ~op_legal(op);

    assign iord     = ctrl.iord;
    assign regdst   = ctrl.regdst;
    assign memtoreg = ctrl.memtoreg;
    assign alusrca  = ctrl.alusrca;
    assign alusrcb  = ctrl.alusrcb;
    assign immzext  = ctrl.immzext;
    assign pcsrc    = ctrl.pcsrc;
    assign aluop    = ctrl.aluop;
    assign state    = state_q;

endmodule

// File: tb/tb_mc_controller.sv
// Directed table-driven bench for mc_controller plus hand-written corner sequences.
module tb_mc_controller;

    logic       clk;
    logic       reset;
    logic [5:0] op;
    logic       zero;
    logic       pcen, iord, memwrite, irwrite, regdst, memtoreg, regwrite, alusrca;
    logic [1:0] alusrcb, pcsrc, aluop;
    logic       immzext, illegal;
    logic [3:0] state;

    int n_cmp;
    int n_bad;

    mc_controller dut (
        .clk      (clk),
        .reset    (reset),
        .op       (op),
        .zero     (zero),
        .pcen     (pcen),
        .iord     (iord),
        .memwrite (memwrite),
        .irwrite  (irwrite),
        .regdst   (regdst),
        .memtoreg (memtoreg),
        .regwrite (regwrite),
        .alusrca  (alusrca),
        .alusrcb  (alusrcb),
        .immzext  (immzext),
        .pcsrc    (pcsrc),
        .aluop    (aluop),
        .illegal  (illegal),
        .state    (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    localparam logic [5:0] LW = 6'b100011, SW = 6'b101011, RT = 6'b000000, BEQ = 6'b000100;
    localparam logic [5:0] ADDI = 6'b001000, ORI = 6'b001101, J = 6'b000010, BAD = 6'b111111;

    // Output word: {pcen,iord,memwrite,irwrite,regdst,memtoreg,regwrite,alusrca,
    //               alusrcb[1:0],immzext,pcsrc[1:0],aluop[1:0],illegal}
    localparam logic [15:0] W_FETCH  = {1'b1,1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,2'b01,1'b0,2'b00,2'b00,1'b0};
    localparam logic [15:0] W_RST    = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b01,1'b0,2'b00,2'b00,1'b0};
    localparam logic [15:0] W_DEC    = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b11,1'b0,2'b00,2'b00,1'b0};
    localparam logic [15:0] W_DECILL = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b11,1'b0,2'b00,2'b00,1'b1};
    localparam logic [15:0] W_MEMADR = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b10,1'b0,2'b00,2'b00,1'b0};
    localparam logic [15:0] W_MEMRD  = {1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,1'b0,2'b00,2'b00,1'b0};
    localparam logic [15:0] W_MEMWB  = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b1,1'b0,2'b00,1'b0,2'b00,2'b00,1'b0};
    localparam logic [15:0] W_MEMWR  = {1'b0,1'b1,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,1'b0,2'b00,2'b00,1'b0};
    localparam logic [15:0] W_EXE    = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b00,1'b0,2'b00,2'b10,1'b0};
    localparam logic [15:0] W_ALUWB  = {1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,1'b1,1'b0,2'b00,1'b0,2'b00,2'b00,1'b0};
    localparam logic [15:0] W_BR1    = {1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b00,1'b0,2'b01,2'b01,1'b0};
    localparam logic [15:0] W_BR0    = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b00,1'b0,2'b01,2'b01,1'b0};
    localparam logic [15:0] W_ADDIEX = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b10,1'b0,2'b00,2'b00,1'b0};
    localparam logic [15:0] W_ORIEX  = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b10,1'b1,2'b00,2'b11,1'b0};
    localparam logic [15:0] W_IMMWB  = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,2'b00,1'b0,2'b00,2'b00,1'b0};
    localparam logic [15:0] W_JUMP   = {1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,1'b0,2'b10,2'b00,1'b0};

    typedef struct {
        logic        rst;
        logic [5:0]  opc;
        logic        z;
        logic [3:0]  exp_state;
        logic [15:0] exp_word;
    } vec_t;

    vec_t vecs[$];

    function automatic logic [15:0] out_word();
        return {pcen, iord, memwrite, irwrite, regdst, memtoreg, regwrite, alusrca,
                alusrcb, immzext, pcsrc, aluop, illegal};
    endfunction

    task automatic add(input logic r, input logic [5:0] o, input logic z,
                       input logic [3:0] s, input logic [15:0] w);
        vec_t v;
        v.rst = r; v.opc = o; v.z = z; v.exp_state = s; v.exp_word = w;
        vecs.push_back(v);
    endtask

    task automatic check_state(input string name, input logic [3:0] exp);
        n_cmp++;
        if (state !== exp) begin
            n_bad++;
            $display("FAIL %s: state got %0d expected %0d", name, state, exp);
        end
    endtask

    task automatic check_word(input string name, input logic [15:0] exp);
        logic [15:0] got;
        got = out_word();
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: outputs got %b expected %b", name, got, exp);
        end
    endtask

    task automatic check_bit(input string name, input logic got, input logic exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %b expected %b", name, got, exp);
        end
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        reset = 1'b1;
        op    = LW;
        zero  = 1'b0;

        // reset held three cycles
        repeat (3) add(1, LW, 0, 4'd0, W_RST);
        // lw: 0,1,2,3,4
        add(0, LW, 0, 4'd0, W_FETCH); add(0, LW, 0, 4'd1, W_DEC);
        add(0, LW, 0, 4'd2, W_MEMADR); add(0, LW, 0, 4'd3, W_MEMRD);
        add(0, LW, 0, 4'd4, W_MEMWB);
        // sw: 0,1,2,5
        add(0, SW, 0, 4'd0, W_FETCH); add(0, SW, 0, 4'd1, W_DEC);
        add(0, SW, 0, 4'd2, W_MEMADR); add(0, SW, 0, 4'd5, W_MEMWR);
        // beq taken then not taken
        add(0, BEQ, 1, 4'd0, W_FETCH); add(0, BEQ, 1, 4'd1, W_DEC); add(0, BEQ, 1, 4'd8, W_BR1);
        add(0, BEQ, 0, 4'd0, W_FETCH); add(0, BEQ, 0, 4'd1, W_DEC); add(0, BEQ, 0, 4'd8, W_BR0);
        // R-type with zero high: zero must not leak into pcen outside BRANCH
        add(0, RT, 1, 4'd0, W_FETCH); add(0, RT, 1, 4'd1, W_DEC);
        add(0, RT, 1, 4'd6, W_EXE); add(0, RT, 1, 4'd7, W_ALUWB);
        add(0, ADDI, 1, 4'd0, W_FETCH); add(0, ADDI, 1, 4'd1, W_DEC);
        add(0, ADDI, 1, 4'd9, W_ADDIEX); add(0, ADDI, 1, 4'd11, W_IMMWB);
        add(0, ORI, 0, 4'd0, W_FETCH); add(0, ORI, 0, 4'd1, W_DEC);
        add(0, ORI, 0, 4'd10, W_ORIEX); add(0, ORI, 0, 4'd11, W_IMMWB);
        add(0, J, 0, 4'd0, W_FETCH); add(0, J, 0, 4'd1, W_DEC); add(0, J, 0, 4'd12, W_JUMP);
        // illegal opcode: pulse in DECODE, then straight back to FETCH
        add(0, BAD, 0, 4'd0, W_FETCH); add(0, BAD, 0, 4'd1, W_DECILL);
        // sw interrupted by reset in MEMWR
        add(0, SW, 0, 4'd0, W_FETCH); add(0, SW, 0, 4'd1, W_DEC);
        add(0, SW, 0, 4'd2, W_MEMADR); add(1, SW, 0, 4'd5, W_RST);
        add(0, LW, 0, 4'd0, W_FETCH); add(0, LW, 0, 4'd1, W_DEC);

        @(posedge clk);
        #1;
        for (int i = 0; i < vecs.size(); i++) begin
            reset = vecs[i].rst;
            op    = vecs[i].opc;
            zero  = vecs[i].z;
            #1;
            check_state($sformatf("vec%0d_state", i), vecs[i].exp_state);
            check_word($sformatf("vec%0d_outputs", i), vecs[i].exp_word);
            @(posedge clk);
            #1;
        end

        // pcen follows zero combinationally within the BRANCH cycle
        begin
            bit found;
            found = 1'b0;
            reset = 1'b0;
            op    = BEQ;
            zero  = 1'b0;
            for (int c = 0; c < 10 && !found; c++) begin
                #1;
                if (state == 4'd8) found = 1'b1;
                else begin
                    @(posedge clk);
                    #1;
                end
            end
            check_bit("reach_branch", found, 1'b1);
            if (found) begin
                check_bit("branch_pcen_z0", pcen, 1'b0);
                zero = 1'b1;
                #1;
                check_bit("branch_pcen_z1", pcen, 1'b1);
                zero = 1'b0;
                #1;
                check_bit("branch_pcen_z0_again", pcen, 1'b0);
                @(posedge clk);
                #1;
                check_state("after_branch", 4'd0);
            end
        end

        // reset asserted in FETCH suppresses pcen and irwrite immediately
        reset = 1'b1;
        #1;
        check_bit("rst_fetch_pcen", pcen, 1'b0);
        check_bit("rst_fetch_irwrite", irwrite, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/mc_controller.md
# mc_controller

Multi-cycle main control FSM for the 32-bit MIPS core. It sequences the shared ALU, register file, memory port and PC across the steps of each instruction. It emits the 2-bit `aluop` consumed by the existing ALU decoder and all datapath enables and mux selects. It replaces the single-cycle main decoder when the datapath runs with one memory port and one ALU.

## Interface
- No parameters; state and opcode encodings are fixed in the shared package.
- `clk` in 1: single clock; all state changes on rising edge.
- `reset` in 1: synchronous, active-high reset.
- `op` in 6: opcode field of the instruction register, `instr[31:26]`.
- `zero` in 1: ALU zero flag, used for `beq`.
- `pcen` out 1: PC register enable, `pcwrite | (branch & zero)`.
- `iord` out 1: memory address select; 0 = PC, 1 = ALUOut.
- `memwrite` out 1: data memory write enable.
- `irwrite` out 1: instruction register write enable.
- `regdst` out 1: register write address; 0 = rt, 1 = rd.
- `memtoreg` out 1: register write data; 0 = ALUOut, 1 = memory data register.
- `regwrite` out 1: register file write enable.
- `alusrca` out 1: ALU A input; 0 = PC, 1 = register A.
- `alusrcb` out 2: ALU B input; 00 = register B, 01 = constant 4, 10 = extended immediate, 11 = sign-extended immediate << 2.
- `immzext` out 1: immediate extension; 1 = zero-extend (ori), 0 = sign-extend.
- `pcsrc` out 2: next-PC source; 00 = ALU result, 01 = ALUOut, 10 = jump target.
- `aluop` out 2: ALU operation class; 00 = add, 01 = sub, 10 = R-type funct field, 11 = or.
- `illegal` out 1: one-cycle pulse when an unsupported opcode is decoded.
- `state` out 4: current state, for debug and the testbench.

## Operation
- Moore FSM. Every output except `pcen` and `illegal` is a pure function of `state`; anything not listed for a state is 0.
- Opcodes handled: lw 100011, sw 101011, R-type 000000, beq 000100, addi 001000, ori 001101, j 000010.
- States, their active outputs, and transitions:
  - FETCH (0): `irwrite`, `alusrcb`=01, `aluop`=00, `pcsrc`=00, pcwrite. Next: DECODE.
  - DECODE (1): `alusrcb`=11, `aluop`=00 (precomputes the branch target). Next by `op`:
    - lw/sw → MEMADR
    - R-type → EXECUTE
    - beq → BRANCH
    - addi → ADDIEX
    - ori → ORIEX
    - j → JUMP
    - any other opcode → FETCH, with `illegal` high in this DECODE cycle
  - MEMADR (2): `alusrca`, `alusrcb`=10, `aluop`=00. Next: MEMRD for lw, MEMWR for sw.
  - MEMRD (3): `iord`. Next: MEMWB.
  - MEMWB (4): `regwrite`, `memtoreg`, `regdst`=0. Next: FETCH.
  - MEMWR (5): `iord`, `memwrite`. Next: FETCH.
  - EXECUTE (6): `alusrca`, `alusrcb`=00, `aluop`=10. Next: ALUWB.
  - ALUWB (7): `regwrite`, `regdst`=1. Next: FETCH.
  - BRANCH (8): `alusrca`, `alusrcb`=00, `aluop`=01, `pcsrc`=01, branch. Next: FETCH.
  - ADDIEX (9): `alusrca`, `alusrcb`=10, `aluop`=00. Next: IMMWB.
  - ORIEX (10): `alusrca`, `alusrcb`=10, `immzext`, `aluop`=11. Next: IMMWB.
  - IMMWB (11): `regwrite`, `regdst`=0. Next: FETCH.
  - JUMP (12): `pcsrc`=10, pcwrite. Next: FETCH.
- Encodings 13–15 are unreachable. If entered, the FSM returns to FETCH on the next edge with all outputs 0.
- `op` is sampled only in DECODE and MEMADR. The IR is stable in those states because `irwrite` is high only in FETCH.

## Timing
- Reset:
  - With `reset` high at an edge, `state` becomes FETCH.
  - While `reset` is high, `pcen`, `irwrite`, `memwrite`, `regwrite` and `illegal` are forced to 0. The other outputs show FETCH values.
  - The first fetch happens on the first edge after `reset` falls.
- Reset mid-instruction abandons it: no write enable is asserted in the reset cycle, and the next cycle is FETCH.
- Cycles per instruction:
  - lw: 5
  - sw, R-type, addi, ori: 4
  - beq, j: 3
  - illegal opcode: 2
- `pcen` in BRANCH is `zero` of the current cycle, with no registering. `beq` uses the target latched in ALUOut during DECODE.
- `illegal` is combinational from DECODE and `op`; it lasts exactly one cycle.

## Structure
- Shared package `mips_pkg`:
  - state enum (4-bit)
  - opcode constants
  - `aluop` codes (00 add, 01 sub, 10 funct, 11 or), kept consistent with the ALU decoder
  - `alusrcb` and `pcsrc` select codes
- One sub-module: `mc_outdec`, a combinational state → control-word decoder that keeps the output table separate from the next-state logic.
- Top level: state register, next-state logic, reset gating of the write enables, `pcen` and `illegal` logic.

## Test plan
- **Reset:** hold `reset` for 3 cycles with `op`=100011 → `state`=0, all write enables 0. First cycle after release: `irwrite`=1, `pcen`=1.
- **lw:** `op`=100011 → state sequence 0,1,2,3,4,0. MEMWB shows `regwrite`=1, `memtoreg`=1, `regdst`=0.
- **beq:** `op`=000100 run twice, once with `zero`=1 and once with `zero`=0 → sequence 0,1,8,0. In BRANCH, `pcen`=1 in the first run and 0 in the second; `aluop`=01 and `pcsrc`=01 in both.
- **R-type:** `op`=000000 → states 0,1,6,7,0 with `aluop`=10 in EXECUTE.
- **ori:** `op`=001101 → states 0,1,10,11,0 with `aluop`=11 and `immzext`=1 in ORIEX.
- **Illegal opcode and mid-instruction reset:**
  - `op`=111111 → `illegal` pulses for 1 cycle in DECODE, then FETCH.
  - `reset` asserted in MEMWR → `memwrite`=0 in that cycle, then `state`=0.
